alu_seq_unit: RTL and testbench

Parametrised multi-cycle ALU with integrated ALU-control decode for the multi-cycle CPU datapath. It replaces the combinational ALU-control/ALU pair in the EX stage. It accepts an ALUOp class plus funct fields and two operands on a start pulse, and runs one of the following:
- a single-cycle op;
- an iterative shift (SHIFT_STEP bits per cycle);
- optionally, an iterative shift-add multiply.

It returns a held result and branch condition with a one-cycle done pulse. The main control FSM waits on done before leaving EX.

---
 rtl/alu_seq_unit_pkg.sv | 47 ++++
 rtl/alu_seq_unit_shift_step.sv | 25 ++
 rtl/alu_seq_unit.sv | 244 ++++++++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_unit_pkg.sv
// alu_seq_unit_pkg: shared encodings for the sequential ALU.
// ALUOp classes, funct3 constants, the internal operation enum and FSM states.
// MUL_EN adds the MUL state to the FSM encoding.
package alu_seq_unit_pkg;

  // ALUOp class encodings from the main controller
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_ARITH  = 2'b01;
  localparam logic [1:0] ALUOP_BRANCH = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;

  // Arithmetic funct3 values
  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SR   = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;

  // Branch funct3 values
  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA, OP_SLT,
    OP_SLTU, OP_XOR, OP_OR, OP_AND, OP_MUL
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
`ifdef MUL_EN
    ST_MUL,
`endif
    ST_EXEC
  } state_e;

  function automatic logic is_shift(input alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_seq_unit_shift_step.sv
// alu_shift_step: combinational single-step shifter. The caller keeps amt
// at or below the per-cycle step size; arithmetic right shifts replicate
// the current MSB, which is the operand's original sign bit.
module alu_shift_step #(
  parameter int XLEN = 32,
  parameter int AW   = 6
) (
  input  logic [XLEN-1:0] value,
  input  logic            left,
  input  logic            arith,
  input  logic [AW-1:0]   amt,
  output logic [XLEN-1:0] shifted
);

  // Select shift direction and fill
  always_comb begin
    if (left)
      shifted = value << amt;
    else if (arith)
      shifted = $unsigned($signed(value) >>> amt);
    else
      shifted = value >> amt;
  end

endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: multi-cycle ALU with built-in ALU-control decode.
// Define MUL_EN to add the iterative shift-add multiplier.
// busy trails acceptance by one cycle; new requests are only taken in IDLE.
module alu_seq_unit
  import alu_seq_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      alu_ctrl_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            bcond,
  output logic            illegal
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

  state_e          state_reg, state_next;
  alu_op_e         op_reg, dec_op;
  logic [XLEN-1:0] a_reg, b_reg, result_reg, alu_res, fin_res, sh_out;
  logic [2:0]      f3_reg;
  logic [CW-1:0]   cnt_reg, dec_cnt, step, sh_amt;
  logic            br_reg, ill_reg, zero_reg, dec_ill, dec_zero, dec_br;
  logic            busy_reg, done_reg, bcond_reg, illegal_reg;
  logic            accept, fin, last_shift, alu_bcond;
`ifdef MUL_EN
  logic [XLEN-1:0] acc_reg, mul_sum;
`endif

  assign accept     = start && (state_reg == ST_IDLE);
  assign last_shift = (cnt_reg <= STEP);
  assign step       = last_shift ? cnt_reg : STEP;

  // Decode the ALUOp class and funct fields into an internal operation
  always_comb begin
    dec_op   = OP_ADD;
    dec_ill  = 1'b0;
    dec_zero = 1'b0;
    dec_br   = 1'b0;
    case (alu_ctrl_op)
      ALUOP_ARITH: begin
        if (funct7_0) begin
`ifdef MUL_EN
          if (funct3 == FUNCT3_ADD) begin
            dec_op = OP_MUL;
          end else begin
            dec_ill  = 1'b1;
            dec_zero = 1'b1;
          end
`else
          dec_ill  = 1'b1;
          dec_zero = 1'b1;
`endif
        end else begin
          dec_ill = funct7_5 && (funct3 != FUNCT3_ADD) && (funct3 != FUNCT3_SR);
          case (funct3)
            FUNCT3_ADD:  dec_op = funct7_5 ? OP_SUB : OP_ADD;
            FUNCT3_SLL:  dec_op = OP_SLL;
            FUNCT3_SLT:  dec_op = OP_SLT;
            FUNCT3_SLTU: dec_op = OP_SLTU;
            FUNCT3_XOR:  dec_op = OP_XOR;
            FUNCT3_SR:   dec_op = funct7_5 ? OP_SRA : OP_SRL;
            FUNCT3_OR:   dec_op = OP_OR;
            default:     dec_op = OP_AND;
          endcase
        end
      end
      ALUOP_BRANCH: begin
        dec_op  = OP_SUB;
        dec_br  = 1'b1;
        dec_ill = (funct3 == FUNCT3_SLT) || (funct3 == FUNCT3_SLTU);
      end
      default: dec_op = OP_ADD;
    endcase
    if (is_shift(dec_op))
      dec_cnt = CW'(in_b[SW-1:0]);
    else if (dec_op == OP_MUL)
      dec_cnt = CW'(XLEN);
    else
      dec_cnt = '0;
  end

  // The multiplier walks the multiplicand left one bit per cycle
`ifdef MUL_EN
  assign sh_amt  = (state_reg == ST_MUL) ? CW'(1) : step;
  assign mul_sum = acc_reg + (b_reg[0] ? a_reg : '0);
`else
  assign sh_amt = step;
`endif

  alu_shift_step #(.XLEN(XLEN), .AW(CW)) u_shift (
    .value  (a_reg),
    .left   ((op_reg == OP_SLL) || (op_reg == OP_MUL)),
    .arith  (op_reg == OP_SRA),
    .amt    (sh_amt),
    .shifted(sh_out)
  );

  // Single-cycle result and branch condition from the latched operands
  always_comb begin
    alu_res   = '0;
    alu_bcond = 1'b0;
    case (op_reg)
      OP_ADD:  alu_res = a_reg + b_reg;
      OP_SUB:  alu_res = a_reg - b_reg;
      OP_SLL, OP_SRL, OP_SRA: alu_res = sh_out;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a_reg) < $signed(b_reg)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a_reg < b_reg};
      OP_XOR:  alu_res = a_reg ^ b_reg;
      OP_OR:   alu_res = a_reg | b_reg;
      OP_AND:  alu_res = a_reg & b_reg;
      default: alu_res = '0;
    endcase
    case (f3_reg)
      FUNCT3_BEQ:  alu_bcond = (a_reg == b_reg);
      FUNCT3_BNE:  alu_bcond = (a_reg != b_reg);
      FUNCT3_BLT:  alu_bcond = $signed(a_reg) < $signed(b_reg);
      FUNCT3_BGE:  alu_bcond = $signed(a_reg) >= $signed(b_reg);
      FUNCT3_BLTU: alu_bcond = (a_reg < b_reg);
      FUNCT3_BGEU: alu_bcond = (a_reg >= b_reg);
      default:     alu_bcond = 1'b0;
    endcase
    alu_bcond = alu_bcond && br_reg && !ill_reg;
  end

  // Next-state logic and completion detect
  always_comb begin
    state_next = state_reg;
    fin        = 1'b0;
    fin_res    = zero_reg ? '0 : alu_res;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
`ifdef MUL_EN
          state_next = (dec_op == OP_MUL) ? ST_MUL : ST_EXEC;
`else
          state_next = ST_EXEC;
`endif
        end
      end
      ST_EXEC: begin
        if (!is_shift(op_reg) || last_shift) begin
          fin        = 1'b1;
          state_next = ST_IDLE;
        end
      end
`ifdef MUL_EN
      ST_MUL: begin
        fin_res = mul_sum;
        if (cnt_reg == CW'(1)) begin
          fin        = 1'b1;
          state_next = ST_IDLE;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  // Operand latch, iteration registers and held outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= OP_ADD;
      f3_reg      <= '0;
      br_reg      <= 1'b0;
      ill_reg     <= 1'b0;
      zero_reg    <= 1'b0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      result_reg  <= '0;
      bcond_reg   <= 1'b0;
      illegal_reg <= 1'b0;
`ifdef MUL_EN
      acc_reg     <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        a_reg    <= in_a;
        b_reg    <= in_b;
        op_reg   <= dec_op;
        f3_reg   <= funct3;
        br_reg   <= dec_br;
        ill_reg  <= dec_ill;
        zero_reg <= dec_zero;
        cnt_reg  <= dec_cnt;
`ifdef MUL_EN
        acc_reg  <= '0;
`endif
      end
      if (state_reg == ST_EXEC && is_shift(op_reg)) begin
        a_reg   <= sh_out;
        cnt_reg <= cnt_reg - step;
      end
`ifdef MUL_EN
      if (state_reg == ST_MUL) begin
        acc_reg <= mul_sum;
        a_reg   <= sh_out;
        b_reg   <= b_reg >> 1;
        cnt_reg <= cnt_reg - CW'(1);
      end
`endif
      if (fin) begin
        done_reg    <= 1'b1;
        busy_reg    <= 1'b0;
        result_reg  <= fin_res;
        bcond_reg   <= alu_bcond;
        illegal_reg <= ill_reg;
      end else if (state_reg != ST_IDLE) begin
        busy_reg <= 1'b1;
      end
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign result  = result_reg;
  assign bcond   = bcond_reg;
  assign illegal = illegal_reg;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed and random checks of alu_seq_unit against a
// behavioural model written from the instruction semantics.
module tb_alu_seq_unit;

  localparam int XLEN = 32;
  localparam int STEP = 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      alu_ctrl_op = '0;
  logic [2:0]      funct3 = '0;
  logic            funct7_5 = 1'b0;
  logic            funct7_0 = 1'b0;
  logic [XLEN-1:0] in_a = '0;
  logic [XLEN-1:0] in_b = '0;
  logic            busy, done, bcond, illegal;
  logic [XLEN-1:0] result;

  int total = 0;
  int bad   = 0;

  alu_seq_unit #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .alu_ctrl_op(alu_ctrl_op),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .funct7_0   (funct7_0),
    .in_a       (in_a),
    .in_b       (in_b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .bcond      (bcond),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference semantics: what the instruction computes and how long it takes
  function automatic void model(input logic [1:0] op, input logic [2:0] f3,
                                input logic f75, input logic f70,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic bc,
                                output logic ill, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    r   = 32'h0;
    bc  = 1'b0;
    ill = 1'b0;
    lat = 1;
    if (op == 2'b10) begin
      r = a - b;
      case (f3)
        3'd0: bc = (a == b);
        3'd1: bc = (a != b);
        3'd4: bc = ($signed(a) < $signed(b));
        3'd5: bc = ($signed(a) >= $signed(b));
        3'd6: bc = (a < b);
        3'd7: bc = (a >= b);
        default: ill = 1'b1;
      endcase
    end else if (op == 2'b01) begin
      if (f70) begin
`ifdef MUL_EN
        if (f3 == 3'd0) begin
          r   = a * b;
          lat = XLEN;
        end else begin
          ill = 1'b1;
        end
`else
        ill = 1'b1;
`endif
      end else begin
        ill = f75 && (f3 != 3'd0) && (f3 != 3'd5);
        case (f3)
          3'd0: r = f75 ? a - b : a + b;
          3'd1: r = a << sh;
          3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: r = (a < b) ? 32'd1 : 32'd0;
          3'd4: r = a ^ b;
          3'd5: r = f75 ? 32'($signed(a) >>> sh) : a >> sh;
          3'd6: r = a | b;
          default: r = a & b;
        endcase
        if (f3 == 3'd1 || f3 == 3'd5)
          lat = (sh == 0) ? 1 : (sh + STEP - 1) / STEP;
      end
    end else begin
      r = a + b;
    end
  endfunction

  // Issue one request and check timing, busy profile and outputs
  task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                        input logic f75, input logic f70,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic        ebc, eill;
    int          elat, lat, bcnt;
    model(op, f3, f75, f70, a, b, er, ebc, eill, elat);
    @(negedge clk);
    alu_ctrl_op = op; funct3 = f3; funct7_5 = f75; funct7_0 = f70;
    in_a = a; in_b = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({tag, ".busy_T"}, {31'b0, busy}, 32'd0);
    lat = 0;
    bcnt = 0;
    for (int k = 1; k <= XLEN + 8 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (done) lat = k;
      else if (busy) bcnt++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(elat));
    chk({tag, ".busy_cycles"}, 32'(bcnt), 32'(elat - 1));
    chk({tag, ".result"}, result, er);
    chk({tag, ".bcond"}, {31'b0, bcond}, {31'b0, ebc});
    chk({tag, ".illegal"}, {31'b0, illegal}, {31'b0, eill});
    $display("op %s alu_op=%0d f3=%0d f75=%0b f70=%0b a=%08h b=%08h -> res=%08h bc=%0b ill=%0b lat=%0d",
             tag, op, f3, f75, f70, a, b, result, bcond, illegal, lat);
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, {31'b0, done}, 32'd0);
    chk({tag, ".held"}, result, er);
  endtask

  initial begin
    int lat;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.done", {31'b0, done}, 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.bcond", {31'b0, bcond}, 32'd0);
    chk("rst.illegal", {31'b0, illegal}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed cases
    run_op("sub", 2'b01, 3'd0, 1'b1, 1'b0, 32'd5, 32'd7);
    run_op("sra4", 2'b01, 3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'd4);
    run_op("sra0", 2'b01, 3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'd0);
    run_op("blt", 2'b10, 3'd4, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    run_op("bltu", 2'b10, 3'd6, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    run_op("br010", 2'b10, 3'd2, 1'b0, 1'b0, 32'd3, 32'd3);
    run_op("beq", 2'b10, 3'd0, 1'b0, 1'b1, 32'd9, 32'd9);
    run_op("and_f75", 2'b01, 3'd7, 1'b1, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF);
    run_op("rsvd", 2'b11, 3'd5, 1'b1, 1'b1, 32'd40, 32'd2);
    run_op("mul", 2'b01, 3'd0, 1'b0, 1'b1, 32'h0000_FFFF, 32'h0001_0001);
    run_op("f70_or", 2'b01, 3'd6, 1'b0, 1'b1, 32'h1234_5678, 32'h1);

    // Start while busy is ignored; start in the done cycle is accepted
    @(negedge clk);
    alu_ctrl_op = 2'b01; funct3 = 3'd1; funct7_5 = 1'b0; funct7_0 = 1'b0;
    in_a = 32'd1; in_b = 32'd31; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int k = 1; k <= XLEN + 8 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
      end else if (busy) begin
        alu_ctrl_op = 2'b00; in_a = 32'hDEAD_0000 + 32'(k); in_b = 32'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("sll31.latency", 32'(lat), 32'd31);
    chk("sll31.result", result, 32'h8000_0000);
    $display("op sll31_with_busy_starts res=%08h lat=%0d", result, lat);
    alu_ctrl_op = 2'b00; in_a = 32'd7; in_b = 32'd8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b.accept_done", {31'b0, done}, 32'd0);
    @(posedge clk);
    #1;
    chk("b2b.done", {31'b0, done}, 32'd1);
    chk("b2b.result", result, 32'd15);
    $display("op b2b_add res=%08h done=%0b", result, done);

    // Reset in the middle of a shift aborts it
    @(negedge clk);
    alu_ctrl_op = 2'b01; funct3 = 3'd1; in_a = 32'd3; in_b = 32'd20; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort.busy", {31'b0, busy}, 32'd0);
    chk("abort.done", {31'b0, done}, 32'd0);
    chk("abort.result", result, 32'd0);
    $display("op abort_mid_shift busy=%0b done=%0b res=%08h", busy, done, result);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("add_after_rst", 2'b00, 3'd0, 1'b0, 1'b0, 32'd2, 32'd3);

    // Random requests against the model
    for (int i = 0; i < 30; i++) begin
      logic [1:0]  rop;
      logic [2:0]  rf3;
      logic        r75, r70;
      logic [31:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      rf3 = 3'($urandom_range(0, 7));
      r75 = 1'($urandom_range(0, 1));
      r70 = ($urandom_range(0, 3) == 0);
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) rb = ra;
      run_op($sformatf("rnd%0d", i), rop, rf3, r75, r70, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
